// File: rtl/wb_pkg.sv
// Shared types and widths for the pixel write-back drain.
// ADDR_W/PIX_W: image RAM address and pixel widths; LANES: pixels per triple.
// wb_entry_t: one buffered triple, lane i in addr[i]/data[i].
// ser_state_t: serializer states.
package wb_pkg;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 18;
    localparam int LANES  = 3;

    typedef struct packed {
        logic [LANES-1:0][ADDR_W-1:0] addr;
        logic [LANES-1:0][PIX_W-1:0]  data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2,
        LANE2 = 2'd3
    } ser_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write triples.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (pointers/count only)
//   push, wdata    offer an entry; ignored while full
//   pop            release the head entry; ignored while empty
//   head           entry at the read pointer
//   head_next      entry one slot behind the head (valid when count >= 2)
//   full, empty    derived from the registered count
//   count          occupancy, 0..DEPTH
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        wdata,
    input  logic             pop,
    output wb_entry_t        head,
    output wb_entry_t        head_next,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // full is taken from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_W'(1)];

    // Storage carries no reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_pixel_drain.sv
// Drains GPU pixel write triples into a single-port image RAM, one lane
// per accepted RAM cycle, in lane order 0, 1, 2.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   MemWriteM           offer {A1,A2,A3,writeData} this cycle
//   A1, A2, A3          lane 0/1/2 addresses
//   writeData           lane pixel data, lane i with A(i+1)
//   full                FIFO full; GPU must stall
//   ram_we/addr/wdata   registered RAM write request
//   ram_ready           RAM accepts the current request
//   idle                FIFO empty and serializer idle
//   overflow            sticky: a triple was offered while full
//
// state | meaning
// IDLE  | no triple in service, ram_we low, addr/data hold last values
// LANE0 | presenting lane 0 of the registered triple
// LANE1 | presenting lane 1
// LANE2 | presenting lane 2; acceptance pops the FIFO head
module wb_pixel_drain
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        MemWriteM,
    input  logic [ADDR_W-1:0]           A1,
    input  logic [ADDR_W-1:0]           A2,
    input  logic [ADDR_W-1:0]           A3,
    input  logic [LANES-1:0][PIX_W-1:0] writeData,
    output logic                        full,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [PIX_W-1:0]            ram_wdata,
    input  logic                        ram_ready,
    output logic                        idle,
    output logic                        overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ser_state_t       state;
    wb_entry_t        cur;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        head_next;
    wb_entry_t        next_entry;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push_ok;
    logic             more_after_pop;

    assign push_entry.addr = {A3, A2, A1};
    assign push_entry.data = writeData;

    assign pop     = (state == LANE2) && ram_ready;
    assign push_ok = MemWriteM && !full;

    // The head is still the triple in service, so the follow-on triple is
    // the slot behind it, or the one being pushed this very edge when the
    // head is the only entry. Bypassing the push keeps the stream gap-free.
    assign more_after_pop = (count > CNT_W'(1)) || push_ok;
    assign next_entry     = (count > CNT_W'(1)) ? head_next : push_entry;

    assign idle = empty && (state == IDLE);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (MemWriteM),
        .wdata     (push_entry),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cur       <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            overflow  <= 1'b0;
        end else begin
            if (MemWriteM && full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur       <= head;
                        state     <= LANE0;
                        ram_we    <= 1'b1;
                        ram_addr  <= head.addr[0];
                        ram_wdata <= head.data[0];
                    end
                end
                LANE0: begin
                    if (ram_ready) begin
                        state     <= LANE1;
                        ram_addr  <= cur.addr[1];
                        ram_wdata <= cur.data[1];
                    end
                end
                LANE1: begin
                    if (ram_ready) begin
                        state     <= LANE2;
                        ram_addr  <= cur.addr[2];
                        ram_wdata <= cur.data[2];
                    end
                end
                LANE2: begin
                    if (ram_ready) begin
                        if (more_after_pop) begin
                            cur       <= next_entry;
                            state     <= LANE0;
                            ram_addr  <= next_entry.addr[0];
                            ram_wdata <= next_entry.data[0];
                        end else begin
                            state  <= IDLE;
                            ram_we <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_pixel_drain.sv
module tb_wb_pixel_drain;

    logic             CLK;
    logic             RST;
    logic             MemWriteM;
    logic [18:0]      A1, A2, A3;
    logic [2:0][17:0] writeData;
    logic             full;
    logic             ram_we;
    logic [18:0]      ram_addr;
    logic [17:0]      ram_wdata;
    logic             ram_ready;
    logic             idle;
    logic             overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic full_seen = 1'b0;

    logic [18:0] log_a[$];
    logic [17:0] log_d[$];
    int          log_c[$];

    wb_pixel_drain #(.FIFO_DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemWriteM (MemWriteM),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .writeData (writeData),
        .full      (full),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ready (ram_ready),
        .idle      (idle),
        .overflow  (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Records every accepted RAM write (values as seen just before the edge).
    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (full) full_seen = 1'b1;
        if (!RST && ram_we && ram_ready) begin
            log_a.push_back(ram_addr);
            log_d.push_back(ram_wdata);
            log_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        MemWriteM = 1'b0;
        ram_ready = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        clear_log();
    endtask

    task automatic offer(input logic [18:0] a0, input logic [18:0] a1, input logic [18:0] a2,
                         input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] d2);
        MemWriteM    = 1'b1;
        A1           = a0;
        A2           = a1;
        A3           = a2;
        writeData[0] = d0;
        writeData[1] = d1;
        writeData[2] = d2;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (!idle && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mm;
        int n11;
        logic [18:0] ea;
        logic [17:0] ed;

        RST = 1'b1; MemWriteM = 1'b0; ram_ready = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; writeData = '0;
        tick();
        tick();
        // Reset values
        check("rst_we",    32'(ram_we),    32'd0);
        check("rst_addr",  32'(ram_addr),  32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_full",  32'(full),      32'd0);
        check("rst_idle",  32'(idle),      32'd1);
        check("rst_ovf",   32'(overflow),  32'd0);
        RST = 1'b0;
        clear_log();

        // Single triple: lane 0 shows two cycles after the push edge
        ram_ready = 1'b1;
        offer(19'h00010, 19'h00011, 19'h00012, 18'h3FFFF, 18'h00001, 18'h2AAAA);
        tick();
        MemWriteM = 1'b0;
        check("t1_we_after_push", 32'(ram_we), 32'd0);
        check("t1_not_idle",      32'(idle),   32'd0);
        tick();
        check("t1_l0_we",   32'(ram_we),    32'd1);
        check("t1_l0_addr", 32'(ram_addr),  32'h00010);
        check("t1_l0_data", 32'(ram_wdata), 32'h3FFFF);
        tick();
        check("t1_l1_addr", 32'(ram_addr),  32'h00011);
        check("t1_l1_data", 32'(ram_wdata), 32'h00001);
        tick();
        check("t1_l2_addr", 32'(ram_addr),  32'h00012);
        check("t1_l2_data", 32'(ram_wdata), 32'h2AAAA);
        tick();
        check("t1_end_we",   32'(ram_we),   32'd0);
        check("t1_end_idle", 32'(idle),     32'd1);
        check("t1_end_hold", 32'(ram_addr), 32'h00012);
        check("t1_nwrites",  32'(log_a.size()), 32'd3);

        // Backpressure in LANE1
        clear_log();
        offer(19'h00010, 19'h00011, 19'h00012, 18'h3FFFF, 18'h00001, 18'h2AAAA);
        tick();
        MemWriteM = 1'b0;
        tick();
        tick();
        ram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_we",   32'(ram_we),    32'd1);
            check("t2_stall_addr", 32'(ram_addr),  32'h00011);
            check("t2_stall_data", 32'(ram_wdata), 32'h00001);
            tick();
        end
        ram_ready = 1'b1;
        wait_idle(20, "t2_idle");
        n11 = 0;
        foreach (log_a[k]) if (log_a[k] == 19'h00011) n11++;
        check("t2_lane1_writes", 32'(n11), 32'd1);
        check("t2_nwrites", 32'(log_a.size()), 32'd3);

        // Fill with RAM stalled: 4 accepted, 5th dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            offer(19'(32'h100 + i*4), 19'(32'h101 + i*4), 19'(32'h102 + i*4),
                  18'(32'h1000 + i*4), 18'(32'h1001 + i*4), 18'(32'h1002 + i*4));
            tick();
            if (i == 2) check("t3_full_after3", 32'(full), 32'd0);
            if (i == 3) begin
                check("t3_full_after4", 32'(full), 32'd1);
                check("t3_ovf_after4",  32'(overflow), 32'd0);
            end
            if (i == 4) check("t3_ovf_after5", 32'(overflow), 32'd1);
        end
        MemWriteM = 1'b0;
        ram_ready = 1'b1;
        wait_idle(60, "t3_idle");
        check("t3_nwrites", 32'(log_a.size()), 32'd12);
        mm = 0;
        for (int k = 0; k < 12; k++) begin
            ea = 19'(32'h100 + (k / 3) * 4 + (k % 3));
            ed = 18'(32'h1000 + (k / 3) * 4 + (k % 3));
            if (k >= log_a.size() || log_a[k] !== ea || log_d[k] !== ed) mm++;
        end
        check("t3_order", 32'(mm), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Full with a same-cycle LANE2 pop: push still dropped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            offer(19'(32'h200 + i*4), 19'(32'h201 + i*4), 19'(32'h202 + i*4),
                  18'(32'h2000 + i), 18'(32'h2100 + i), 18'(32'h2200 + i));
            tick();
        end
        MemWriteM = 1'b0;
        check("t4_full", 32'(full), 32'd1);
        ram_ready = 1'b1;
        tick();
        tick();
        check("t4_lane2_addr", 32'(ram_addr), 32'h202);
        offer(19'h3F0, 19'h3F1, 19'h3F2, 18'h0, 18'h0, 18'h0);
        tick();
        MemWriteM = 1'b0;
        check("t4_ovf",       32'(overflow), 32'd1);
        check("t4_not_full",  32'(full),     32'd0);
        check("t4_next_addr", 32'(ram_addr), 32'h204);
        wait_idle(40, "t4_idle");
        check("t4_nwrites", 32'(log_a.size()), 32'd12);
        mm = 0;
        foreach (log_a[k]) if (log_a[k] >= 19'h3F0 && log_a[k] <= 19'h3F2) mm++;
        check("t4_dropped_absent", 32'(mm), 32'd0);

        // Streaming: one triple every 3rd cycle
        do_reset();
        ram_ready = 1'b1;
        full_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            offer(19'(32'h400 + k*4), 19'(32'h401 + k*4), 19'(32'h402 + k*4),
                  18'(32'h3000 + k*4), 18'(32'h3001 + k*4), 18'(32'h3002 + k*4));
            tick();
            MemWriteM = 1'b0;
            tick();
            tick();
        end
        wait_idle(20, "t5_idle");
        check("t5_nwrites", 32'(log_a.size()), 32'd60);
        if (log_c.size() == 60)
            check("t5_no_gaps", 32'(log_c[59] - log_c[0]), 32'd59);
        else
            check("t5_no_gaps_len", 32'(log_c.size()), 32'd60);
        check("t5_full_never", 32'(full_seen), 32'd0);
        mm = 0;
        for (int k = 0; k < 60; k++) begin
            ea = 19'(32'h400 + (k / 3) * 4 + (k % 3));
            ed = 18'(32'h3000 + (k / 3) * 4 + (k % 3));
            if (k >= log_a.size() || log_a[k] !== ea || log_d[k] !== ed) mm++;
        end
        check("t5_order", 32'(mm), 32'd0);

        // Reset while in LANE1 with two more entries queued
        do_reset();
        ram_ready = 1'b1;
        offer(19'h500, 19'h501, 19'h502, 18'h1, 18'h2, 18'h3);
        tick();
        offer(19'h504, 19'h505, 19'h506, 18'h4, 18'h5, 18'h6);
        tick();
        offer(19'h508, 19'h509, 19'h50A, 18'h7, 18'h8, 18'h9);
        tick();
        MemWriteM = 1'b0;
        check("t6_in_lane1", 32'(ram_addr), 32'h501);
        RST = 1'b1;
        #1;
        check("t6_rst_we",   32'(ram_we), 32'd0);
        check("t6_rst_idle", 32'(idle),   32'd1);
        clear_log();
        tick();
        tick();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_writes", 32'(log_a.size()), 32'd0);
        check("t6_we_low",    32'(ram_we), 32'd0);
        check("t6_idle",      32'(idle),   32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_pixel_drain.md
WB_PIXEL_DRAIN -- requirements
Module: wb_pixel_drain

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered write triples (power of 2, >=2).
REQ-002 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  GPU memory-stage write strobe; one triple offered per cycle when high.
- A1, A2, A3  in  19 each  pixel addresses for lanes 0, 1, 2.
- writeData  in  [2:0][17:0]  lane pixel data; lane i pairs with address A(i+1).
- full  out  1  FIFO holds FIFO_DEPTH entries; GPU SHALL stall while high.
- ram_we  out  1  single-port image RAM write request.
- ram_addr  out  19  RAM write address.
- ram_wdata  out  18  RAM write data.
- ram_ready  in  1  RAM accepts the current request this cycle.
- idle  out  1  FIFO empty and serializer in IDLE.
- overflow  out  1  sticky: a triple was offered while full.

Function
REQ-003 SHALL push {A1,A2,A3,writeData} into the FIFO on a rising edge when MemWriteM=1 and full=0.
REQ-004 SHALL derive full from the registered occupancy count only; a pop in the same cycle does not free room for a push while full=1.
REQ-005 SHALL drop a triple offered while full=1, leave the FIFO unchanged and set overflow=1 until reset.
REQ-006 SHALL run a serializer FSM with states IDLE, LANE0, LANE1, LANE2.
REQ-007 IDLE -> LANE0 when the FIFO is non-empty; the head entry is registered into the serializer on that edge.
REQ-008 In LANEk, SHALL drive ram_we=1, ram_addr=lane k address, ram_wdata=lane k data, all from registers.
REQ-009 LANEk SHALL hold all RAM outputs stable while ram_ready=0 (no timeout).
REQ-010 On ram_ready=1: LANE0->LANE1, LANE1->LANE2.
REQ-011 On ram_ready=1 in LANE2, SHALL pop the head. Next state is LANE0 with the next head loaded if the FIFO still holds an entry after the pop, otherwise IDLE.
REQ-012 In IDLE, SHALL drive ram_we=0, with ram_addr and ram_wdata holding their last values.
REQ-013 Latency: a triple pushed into an empty FIFO with the FSM in IDLE SHALL appear as ram_we=1 (lane 0) in the second cycle after the push edge.
REQ-014 Throughput with ram_ready tied high SHALL be 3 cycles per triple, with no IDLE bubble between back-to-back entries.
REQ-015 Simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-016 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
REQ-017 Lanes SHALL always be written in order 0, 1, 2; duplicate addresses are written in that order, so the last write wins.
REQ-018 idle SHALL equal (count==0) and (state==IDLE).

Reset
REQ-019 RST=1 SHALL immediately force state=IDLE, pointers and count to 0, overflow=0, ram_we=0, ram_addr=0, ram_wdata=0, full=0, idle=1.
REQ-020 Reset asserted mid-triple SHALL discard the buffered triple and all remaining lanes; no ram_we is issued until a new push.
REQ-021 FIFO storage SHALL NOT require reset.

Structure
REQ-022 Shared package wb_pkg SHALL hold ADDR_W=19, PIX_W=18, LANES=3, the wb_entry_t packed struct {addr[3], data[3]} and the serializer state enum.
REQ-023 SHALL contain exactly one sub-module, wb_fifo (synchronous FIFO of wb_entry_t, push/pop/full/empty/count); the FSM lives in wb_pixel_drain.

Verification
REQ-024 Single triple: push A=(0x00010,0x00011,0x00012), data=(0x3FFFF,0x00001,0x2AAAA), ram_ready=1 -> three consecutive writes starting 2 cycles after push, in lane order, then idle=1.
REQ-025 Backpressure: ram_ready=0 for 5 cycles in LANE1 -> ram_addr=0x00011 and ram_wdata=0x00001 stable for all 5 cycles; exactly one LANE1 write on release.
REQ-026 Fill: 5 consecutive pushes with ram_ready=0 -> full=1 after the 4th push; the 5th is dropped and overflow=1; exactly 12 writes drain once ram_ready=1.
REQ-027 Full plus pop: full=1 and LANE2 accepted in the same cycle as MemWriteM=1 -> push dropped, overflow=1, count=3.
REQ-028 Streaming: MemWriteM pulsed every 3rd cycle with ram_ready=1 for 20 triples -> 60 writes, no gaps after the first, full never asserted.
REQ-029 Reset mid-op: RST pulsed while in LANE1 with 2 entries queued -> ram_we=0 immediately, idle=1, no further writes.
